fp_sq_accum: RTL

FP_SQ_ACCUM -- requirements
Module: fp_sq_accum

---
 rtl/fp_accum_pkg.sv | 20 ++
 rtl/fp_align_shift.sv | 50 +++++
 rtl/fp_sq_accum.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fp_accum_pkg.sv
// Shared field widths, exponent limit and controller state encoding for the sum-of-squares accumulator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp_accum_pkg;

    localparam int EXP_W    = 9;
    localparam int IN_SIG_W = 30;
    localparam int IN_W     = EXP_W + IN_SIG_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 9'd511;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_IN = 3'd1,
        ADD     = 3'd2,
        NORM    = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/fp_align_shift.sv
// Aligns the running accumulator and a new squared element to a common exponent.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs when it accepts an element.
module fp_align_shift
    import fp_accum_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [EXP_W-1:0]    acc_exp_i,
    input  logic [ACC_W-1:0]    acc_sig_i,
    input  logic [EXP_W-1:0]    in_exp_i,
    input  logic [IN_SIG_W-1:0] in_sig_i,
    output logic [ACC_W-1:0]    op_a_o,
    output logic [ACC_W-1:0]    op_b_o,
    output logic [EXP_W-1:0]    res_exp_o
);

    // Truncating right shift; anything at or beyond the full width leaves nothing.
    function automatic logic [ACC_W-1:0] shr(input logic [ACC_W-1:0] x,
                                             input logic [EXP_W-1:0] d);
        if (32'(d) >= ACC_W) begin
            return '0;
        end
        return x >> d;
    endfunction

    logic [ACC_W-1:0] in_ext;
    assign in_ext = ACC_W'(in_sig_i);

    // An empty accumulator adopts the element's exponent; otherwise the smaller operand is shifted down.
    always_comb begin
        op_a_o    = acc_sig_i;
        op_b_o    = in_ext;
        res_exp_o = acc_exp_i;
        if (acc_sig_i == '0) begin
            op_a_o    = '0;
            op_b_o    = in_ext;
            res_exp_o = in_exp_i;
        end else if (acc_exp_i >= in_exp_i) begin
            op_a_o    = acc_sig_i;
            op_b_o    = shr(in_ext, acc_exp_i - in_exp_i);
            res_exp_o = acc_exp_i;
        end else begin
            op_a_o    = shr(acc_sig_i, in_exp_i - acc_exp_i);
            op_b_o    = in_ext;
            res_exp_o = in_exp_i;
        end
    end

endmodule

// File: rtl/fp_sq_accum.sv
// Accumulates a vector of squared floating-point elements into one exponent/significand sum.
// Latency: 2 cycles per element plus 1 normalise cycle; len=1 gives out_valid 4 cycles after start.
// Backpressure: in_ready only in WAIT_IN; result held in DONE until out_ready. FP_ACCUM_NORM_EN enables normalisation.
module fp_sq_accum
    import fp_accum_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_prod,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+ACC_W-1:0] out_sum,
    output logic                   out_ovf,
    output logic                   busy
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [EXP_W-1:0] acc_exp_q, acc_exp_d;
    logic [ACC_W-1:0] acc_sig_q, acc_sig_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] opa_q, opa_d;
    logic [ACC_W-1:0] opb_q, opb_d;
    logic [EXP_W-1:0] exp_q, exp_d;

    logic [ACC_W-1:0] al_a, al_b;
    logic [EXP_W-1:0] al_exp;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] norm_sig;
    logic [EXP_W-1:0] norm_exp;

    fp_align_shift #(.ACC_W(ACC_W)) u_align (
        .acc_exp_i (acc_exp_q),
        .acc_sig_i (acc_sig_q),
        .in_exp_i  (in_prod[IN_W-1:IN_SIG_W]),
        .in_sig_i  (in_prod[IN_SIG_W-1:0]),
        .op_a_o    (al_a),
        .op_b_o    (al_b),
        .res_exp_o (al_exp)
    );

    assign sum_w = {1'b0, opa_q} + {1'b0, opb_q};

`ifdef FP_ACCUM_NORM_EN
    // Shift the leading one to the MSB; the exponent floors at 0 while the shift still completes.
    always_comb begin
        int lz;
        lz = ACC_W;
        for (int i = 0; i < ACC_W; i++) begin
            if (acc_sig_q[i]) begin
                lz = ACC_W - 1 - i;
            end
        end
        norm_sig = '0;
        norm_exp = '0;
        if (acc_sig_q != '0) begin
            norm_sig = acc_sig_q << lz;
            norm_exp = (lz >= int'(acc_exp_q)) ? '0 : acc_exp_q - EXP_W'(lz);
        end
    end
`else
    assign norm_sig = acc_sig_q;
    assign norm_exp = acc_exp_q;
`endif

    // Controller next state plus accumulator, counter and operand-pair updates.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_exp_d = acc_exp_q;
        acc_sig_d = acc_sig_q;
        ovf_d     = ovf_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        exp_d     = exp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_exp_d = '0;
                    acc_sig_d = '0;
                    ovf_d     = 1'b0;
                    count_d   = len;
                    state_d   = (len == '0) ? DONE : WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    opa_d   = al_a;
                    opb_d   = al_b;
                    exp_d   = al_exp;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sum_w[ACC_W]) begin
                    if (exp_q == EXP_MAX) begin
                        acc_exp_d = EXP_MAX;
                        acc_sig_d = '1;
                        ovf_d     = 1'b1;
                    end else begin
                        acc_exp_d = exp_q + EXP_W'(1);
                        acc_sig_d = sum_w[ACC_W:1];
                    end
                end else begin
                    acc_exp_d = exp_q;
                    acc_sig_d = sum_w[ACC_W-1:0];
                end
                count_d = count_q - LEN_W'(1);
                state_d = (count_q == LEN_W'(1)) ? NORM : WAIT_IN;
            end
            NORM: begin
                acc_exp_d = norm_exp;
                acc_sig_d = norm_sig;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partially accumulated vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_exp_q <= '0;
            acc_sig_q <= '0;
            ovf_q     <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_exp_q <= acc_exp_d;
            acc_sig_q <= acc_sig_d;
            ovf_q     <= ovf_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            exp_q     <= exp_d;
        end
    end

    assign in_ready  = (state_q == WAIT_IN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = {acc_exp_q, acc_sig_q};
    assign out_ovf   = ovf_q;

endmodule
